// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm matrix-vector multiplier and its stream controller:
// controller state codes and the row-major element offset used to slice the flattened buses.
package mvm_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_M = 3'd1;
    localparam logic [2:0] ST_LOAD_V = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD_M = ST_LOAD_M,
        S_LOAD_V = ST_LOAD_V,
        S_START  = ST_START,
        S_WAIT   = ST_WAIT,
        S_DRAIN  = ST_DRAIN
    } ctrl_state_e;

    // LSB of element (row, col) in a row-major bus whose element (0,0) sits at the top.
    function automatic int elem_lsb(input int row, input int col, input int rows,
                                    input int cols, input int width);
        return width * cols * (rows - row) - width * col - width;
    endfunction

endpackage

// File: rtl/mvm_stream_ctrl.sv
// Stream front/back end for mvm: loads matrix/vector from an element stream, starts mvm,
// captures the result and replays it row by row on an output stream.
module mvm_stream_ctrl
    import mvm_pkg::*;
#(
    parameter int MATRIX_ROWS = 6,
    parameter int SHARED_DIM  = 3,
    parameter int WIDTH       = 8
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    in_valid,
    input  logic [WIDTH-1:0]                        in_data,
    output logic                                    in_ready,
    input  logic                                    reuse_weights,
    output logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
    output logic [SHARED_DIM*WIDTH-1:0]             vector,
    output logic                                    mvm_start,
    input  logic                                    mvm_done,
    input  logic [MATRIX_ROWS*WIDTH-1:0]            mvm_result,
    output logic                                    out_valid,
    output logic [WIDTH-1:0]                        out_data,
    output logic                                    out_last,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic [2:0]                              dbg_state
);

    // Valid/ready: a beat transfers on a rising edge where valid and ready are both high;
    // neither side may make its valid depend on the other side's ready.
    localparam int M_ELEMS = MATRIX_ROWS * SHARED_DIM;
    localparam int IDX_W   = $clog2(M_ELEMS + 1);
    localparam int RIDX_W  = $clog2(MATRIX_ROWS + 1);
    localparam logic [IDX_W-1:0]  M_LAST = IDX_W'(M_ELEMS - 1);
    localparam logic [IDX_W-1:0]  V_LAST = IDX_W'(SHARED_DIM - 1);
    localparam logic [RIDX_W-1:0] R_LAST = RIDX_W'(MATRIX_ROWS - 1);

    ctrl_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [RIDX_W-1:0]                    ridx_q, ridx_d;
    logic                                 wv_q, wv_d;
    logic [M_ELEMS*WIDTH-1:0]             matrix_q, matrix_d;
    logic [SHARED_DIM*WIDTH-1:0]          vector_q, vector_d;
    logic [MATRIX_ROWS*WIDTH-1:0]         result_q, result_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ridx_q   <= '0;
            wv_q     <= 1'b0;
            matrix_q <= '0;
            vector_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ridx_q   <= ridx_d;
            wv_q     <= wv_d;
            matrix_q <= matrix_d;
            vector_q <= vector_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ridx_d    = ridx_q;
        wv_d      = wv_q;
        matrix_d  = matrix_q;
        vector_d  = vector_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        mvm_start = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;

        case (state_q)
            S_IDLE: begin
                state_d = (reuse_weights && wv_q) ? S_LOAD_V : S_LOAD_M;
            end
            S_LOAD_M: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int r = 0; r < MATRIX_ROWS; r++) begin
                        for (int c = 0; c < SHARED_DIM; c++) begin
                            if (idx_q == IDX_W'(r * SHARED_DIM + c)) begin
                                matrix_d[elem_lsb(r, c, MATRIX_ROWS, SHARED_DIM, WIDTH) +: WIDTH] = in_data;
                            end
                        end
                    end
                    if (idx_q == M_LAST) begin
                        idx_d   = '0;
                        wv_d    = 1'b1;
                        state_d = S_LOAD_V;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_LOAD_V: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int k = 0; k < SHARED_DIM; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            vector_d[WIDTH * (SHARED_DIM - k) - WIDTH +: WIDTH] = in_data;
                        end
                    end
                    if (idx_q == V_LAST) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_START: begin
                mvm_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mvm_done) begin
                    result_d = mvm_result;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                for (int r = 0; r < MATRIX_ROWS; r++) begin
                    if (ridx_q == RIDX_W'(r)) begin
                        out_data = result_q[WIDTH * (MATRIX_ROWS - r) - WIDTH +: WIDTH];
                    end
                end
                out_last = (ridx_q == R_LAST);
                if (out_ready) begin
                    if (ridx_q == R_LAST) begin
                        ridx_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        ridx_d = ridx_q + RIDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign matrix    = matrix_q;
    assign vector    = vector_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
